// File: rtl/accel_run_ctrl.sv
// Run controller for the accelerator: loads weight/ifmap scratchpads from the
// host, sequences per-channel route passes and buffers ofmap results in a FIFO.
module accel_run_ctrl #(
   parameter int SRAM_DATA_WIDTH = 64,
   parameter int ADDR_WIDTH      = 8,
   parameter int DATA_WIDTH      = 8,
   parameter int OFIFO_DEPTH     = 8,
   parameter int CYC_WIDTH       = 32,
   parameter int TIMEOUT         = 65535
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [ADDR_WIDTH-1:0]      i_w_words,
   input  logic [ADDR_WIDTH-1:0]      i_i_words,
   input  logic [ADDR_WIDTH-1:0]      i_c_size,
   input  logic [SRAM_DATA_WIDTH-1:0] i_ld_data,
   input  logic                       i_ld_valid,
   output logic                       o_ld_ready,
   output logic [SRAM_DATA_WIDTH-1:0] o_acc_data_in,
   output logic [ADDR_WIDTH-1:0]      o_acc_write_addr,
   output logic                       o_acc_spad_select,
   output logic                       o_acc_write_en,
   output logic                       o_acc_reg_clear,
   output logic                       o_acc_route_en,
   output logic [ADDR_WIDTH-1:0]      o_acc_i_addr_end,
   output logic [ADDR_WIDTH-1:0]      o_acc_i_c,
   input  logic [2*DATA_WIDTH-1:0]    i_acc_ofmap,
   input  logic                       i_acc_ofmap_valid,
   input  logic                       i_acc_done,
   output logic [2*DATA_WIDTH-1:0]    o_out_data,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [CYC_WIDTH-1:0]       o_cycles,
   output logic                       o_overflow,
   output logic                       o_timeout
);

   localparam int OW = 2 * DATA_WIDTH;
   localparam int PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1) + 1;
   localparam logic [TW-1:0] PASS_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_W, LOAD_I, SETTLE, CLEAR, ROUTE, GAP, FINISH
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] w_words;
   logic [ADDR_WIDTH-1:0] i_words;
   logic [ADDR_WIDTH-1:0] c_size;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   ch_next;
   logic                  settle_cnt;
   logic [TW-1:0]         pass_cnt;
   logic                  start_ok;

   // Handshake: a load word transfers on a rising edge where i_ld_valid and
   // o_ld_ready are both high; an ofmap pops where o_out_valid and i_out_ready are.
   assign o_acc_write_en   = o_ld_ready & i_ld_valid;
   assign o_acc_data_in    = o_ld_ready ? i_ld_data : '0;
   assign o_acc_write_addr = addr;
   assign ch_next          = {1'b0, o_acc_i_c} + (ADDR_WIDTH + 1)'(1);
   assign start_ok         = (state == IDLE) && i_start;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state             <= IDLE;
         w_words           <= '0;
         i_words           <= '0;
         c_size            <= '0;
         addr              <= '0;
         settle_cnt        <= 1'b0;
         pass_cnt          <= '0;
         o_ld_ready        <= 1'b0;
         o_acc_spad_select <= 1'b0;
         o_acc_reg_clear   <= 1'b0;
         o_acc_route_en    <= 1'b0;
         o_acc_i_addr_end  <= '0;
         o_acc_i_c         <= '0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
         o_cycles          <= '0;
         o_timeout         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  w_words           <= i_w_words;
                  i_words           <= i_i_words;
                  c_size            <= i_c_size;
                  o_cycles          <= '0;
                  o_timeout         <= 1'b0;
                  o_acc_i_c         <= '0;
                  addr              <= '0;
                  o_acc_spad_select <= 1'b0;
                  o_ld_ready        <= 1'b1;
                  o_busy            <= 1'b1;
                  state             <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (i_ld_valid) begin
                  if (addr == w_words - ADDR_WIDTH'(1)) begin
                     addr              <= '0;
                     o_acc_spad_select <= 1'b1;
                     state             <= LOAD_I;
                  end else begin
                     addr <= addr + ADDR_WIDTH'(1);
                  end
               end
            end
            LOAD_I: begin
               if (i_ld_valid) begin
                  if (addr == i_words - ADDR_WIDTH'(1)) begin
                     addr              <= '0;
                     o_acc_spad_select <= 1'b0;
                     o_ld_ready        <= 1'b0;
                     o_acc_i_addr_end  <= i_words - ADDR_WIDTH'(1);
                     settle_cnt        <= 1'b0;
                     state             <= SETTLE;
                  end else begin
                     addr <= addr + ADDR_WIDTH'(1);
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt) begin
                  o_acc_reg_clear <= 1'b1;
                  state           <= CLEAR;
               end else begin
                  settle_cnt <= 1'b1;
               end
            end
            CLEAR: begin
               o_acc_reg_clear <= 1'b0;
               o_acc_route_en  <= 1'b1;
               pass_cnt        <= '0;
               state           <= ROUTE;
            end
            ROUTE: begin
               if (o_cycles != '1) o_cycles <= o_cycles + CYC_WIDTH'(1);
               pass_cnt <= pass_cnt + TW'(1);
               // A done in the same cycle the pass budget runs out still counts as a clean pass.
               if (i_acc_done) begin
                  o_acc_route_en <= 1'b0;
                  state          <= GAP;
               end else if (pass_cnt >= PASS_LAST) begin
                  o_acc_route_en <= 1'b0;
                  o_timeout      <= 1'b1;
                  o_done         <= 1'b1;
                  state          <= FINISH;
               end
            end
            GAP: begin
               if (ch_next < {1'b0, c_size}) begin
                  o_acc_i_c      <= ch_next[ADDR_WIDTH-1:0];
                  o_acc_route_en <= 1'b1;
                  pass_cnt       <= '0;
                  state          <= ROUTE;
               end else begin
                  o_done <= 1'b1;
                  state  <= FINISH;
               end
            end
            FINISH: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [OW-1:0] mem [OFIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          full;
   logic          push;
   logic          pop;

   // A pop frees the slot in the same cycle, so a full FIFO still takes a push then.
   assign full        = (count == (PW + 1)'(OFIFO_DEPTH));
   assign pop         = (count != '0) && i_out_ready;
   assign push        = i_acc_ofmap_valid && (!full || pop);
   assign o_out_valid = (count != '0);
   assign o_out_data  = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
         if (start_ok) o_overflow <= 1'b0;
         if (i_acc_ofmap_valid && !push) o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_acc_ofmap;
   end

endmodule
